// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialization sequencer: NOP wait, PRECHARGE ALL, N x AUTO REFRESH,
// LOAD MODE REGISTER, then a sticky init_done that releases the command bus.
module sdram_init_seq #(
  parameter int          T_POWERUP = 10000,
  parameter int          T_RP      = 2,
  parameter int          T_RFC     = 4,
  parameter int          T_MRD     = 2,
  parameter int          REF_COUNT = 8,
  parameter int          ADDR_W    = 13,
  parameter logic [12:0] MODE_REG  = 13'h020
) (
  input  logic              clk_50M,
  input  logic              rst_n,
  output logic              sdram_cke,
  output logic [3:0]        sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [1:0]        sdram_ba,
  output logic              init_done
);

  localparam int WAIT_W = $clog2(T_POWERUP + 1);
  localparam int REF_W  = $clog2(REF_COUNT + 1);

  // Wait states exit when the entry-relative counter reaches these values.
  localparam logic [WAIT_W-1:0] PU_LAST  = WAIT_W'(T_POWERUP - 1);
  localparam logic [WAIT_W-1:0] RP_LAST  = WAIT_W'((T_RP  > 1) ? T_RP  - 2 : 0);
  localparam logic [WAIT_W-1:0] RFC_LAST = WAIT_W'((T_RFC > 1) ? T_RFC - 2 : 0);
  localparam logic [WAIT_W-1:0] MRD_LAST = WAIT_W'((T_MRD > 1) ? T_MRD - 2 : 0);
  localparam logic [REF_W-1:0]  REF_LAST = REF_W'(REF_COUNT - 1);
  localparam logic [REF_W-1:0]  REF_ALL  = REF_W'(REF_COUNT);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  typedef enum logic [2:0] {
    S_WAIT_PU  = 3'd0,
    S_PRE      = 3'd1,
    S_WAIT_RP  = 3'd2,
    S_REF      = 3'd3,
    S_WAIT_RFC = 3'd4,
    S_LMR      = 3'd5,
    S_WAIT_MRD = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WAIT_W-1:0]   r_wait;
  logic [REF_W-1:0]    r_ref;
  logic [3:0]          w_cmd;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_done;

  // State register with wait counter (cleared on every state change) and saturating refresh count.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_WAIT_PU;
      r_wait  <= '0;
      r_ref   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) begin
        r_wait <= '0;
      end else if (r_state == S_DONE) begin
        r_wait <= r_wait;
      end else begin
        r_wait <= r_wait + 1'b1;
      end
      if (r_state == S_REF && r_ref != REF_ALL) begin
        r_ref <= r_ref + 1'b1;
      end else begin
        r_ref <= r_ref;
      end
    end
  end

  // Next-state logic; a wait phase of zero length is bypassed entirely.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT_PU:  w_state_nxt = (r_wait == PU_LAST) ? S_PRE : S_WAIT_PU;
      S_PRE:      w_state_nxt = (T_RP > 1) ? S_WAIT_RP : S_REF;
      S_WAIT_RP:  w_state_nxt = (r_wait == RP_LAST) ? S_REF : S_WAIT_RP;
      S_REF: begin
        if (T_RFC > 1) begin
          w_state_nxt = S_WAIT_RFC;
        end else begin
          w_state_nxt = (r_ref == REF_LAST) ? S_LMR : S_REF;
        end
      end
      S_WAIT_RFC: begin
        if (r_wait == RFC_LAST) begin
          w_state_nxt = (r_ref < REF_ALL) ? S_REF : S_LMR;
        end else begin
          w_state_nxt = S_WAIT_RFC;
        end
      end
      S_LMR:      w_state_nxt = (T_MRD > 1) ? S_WAIT_MRD : S_DONE;
      S_WAIT_MRD: w_state_nxt = (r_wait == MRD_LAST) ? S_DONE : S_WAIT_MRD;
      S_DONE:     w_state_nxt = S_DONE;
      default:    w_state_nxt = S_WAIT_PU;
    endcase
  end

  // Output decode from the upcoming state so the registered bus lines up with the state.
  always_comb begin
    w_cmd  = CMD_NOP;
    w_addr = '0;
    w_done = 1'b0;
    case (w_state_nxt)
      S_PRE: begin
        w_cmd      = CMD_PRE;
        w_addr[10] = 1'b1;
      end
      S_REF:   w_cmd = CMD_REF;
      S_LMR: begin
        w_cmd  = CMD_LMR;
        w_addr = ADDR_W'(MODE_REG);
      end
      S_DONE:  w_done = 1'b1;
      default: w_cmd = CMD_NOP;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      sdram_cke  <= 1'b0;
      sdram_cmd  <= CMD_NOP;
      sdram_addr <= '0;
      sdram_ba   <= 2'b00;
      init_done  <= 1'b0;
    end else begin
      sdram_cke  <= 1'b1;
      sdram_cmd  <= w_cmd;
      sdram_addr <= w_addr;
      sdram_ba   <= 2'b00;
      init_done  <= w_done;
    end
  end

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq: three parameter sets run side by side, each checked every
// cycle against an edge-number timing model plus hand-computed literal expectations.
module tb_sdram_init_seq;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst_a, rst_b, rst_c;
  logic        cke_a, cke_b, cke_c;
  logic [3:0]  cmd_a, cmd_b, cmd_c;
  logic [12:0] addr_a, addr_b, addr_c;
  logic [1:0]  ba_a, ba_b, ba_c;
  logic        done_a, done_b, done_c;

  int n_cmp, n_bad;
  int ea, eb, ec;
  logic pulsed;

  sdram_init_seq #(.T_POWERUP(10), .T_RP(2), .T_RFC(7), .T_MRD(2), .REF_COUNT(2)) dut_a (
    .clk_50M(clk), .rst_n(rst_a), .sdram_cke(cke_a), .sdram_cmd(cmd_a),
    .sdram_addr(addr_a), .sdram_ba(ba_a), .init_done(done_a));

  sdram_init_seq dut_b (
    .clk_50M(clk), .rst_n(rst_b), .sdram_cke(cke_b), .sdram_cmd(cmd_b),
    .sdram_addr(addr_b), .sdram_ba(ba_b), .init_done(done_b));

  sdram_init_seq #(.T_POWERUP(5), .T_RP(1), .T_RFC(1), .T_MRD(1), .REF_COUNT(3)) dut_c (
    .clk_50M(clk), .rst_n(rst_c), .sdram_cke(cke_c), .sdram_cmd(cmd_c),
    .sdram_addr(addr_c), .sdram_ba(ba_c), .init_done(done_c));

  // Edge numbers: E1 is the first rising edge with reset released.
  always @(posedge clk or negedge rst_a) if (!rst_a) ea <= 0; else ea <= ea + 1;
  always @(posedge clk or negedge rst_b) if (!rst_b) eb <= 0; else eb <= eb + 1;
  always @(posedge clk or negedge rst_c) if (!rst_c) ec <= 0; else ec <= ec + 1;

  function automatic logic [3:0] m_cmd(int n, int tpu, int trp, int trfc, int rc);
    if (n == 0) return 4'b0111;
    if (n == tpu) return 4'b0010;
    for (int k = 1; k <= rc; k++)
      if (n == tpu + trp + (k - 1) * trfc) return 4'b0001;
    if (n == tpu + trp + rc * trfc) return 4'b0000;
    return 4'b0111;
  endfunction

  function automatic logic [12:0] m_addr(int n, int tpu, int trp, int trfc, int rc);
    if (n >= 1 && n == tpu) return 13'h400;
    if (n >= 1 && n == tpu + trp + rc * trfc) return 13'h020;
    return 13'h000;
  endfunction

  task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @E%0d: got 0x%0h, expected 0x%0h", nm, n, act, exp);
    end
  endtask

  task automatic check_inst(input string tag, input int n, input int tpu, input int trp,
                            input int trfc, input int tmrd, input int rc,
                            input logic cke, input logic [3:0] cmd, input logic [12:0] addr,
                            input logic [1:0] ba, input logic done);
    chk({tag, ".cke"},  n, 32'(cke),  32'(n >= 1));
    chk({tag, ".cmd"},  n, 32'(cmd),  32'(m_cmd(n, tpu, trp, trfc, rc)));
    chk({tag, ".addr"}, n, 32'(addr), 32'(m_addr(n, tpu, trp, trfc, rc)));
    chk({tag, ".ba"},   n, 32'(ba),   32'd0);
    chk({tag, ".done"}, n, 32'(done), 32'(n >= 1 && n >= tpu + trp + rc * trfc + tmrd));
  endtask

  // Literal expectations worked out by hand from the timing rules.
  task automatic lit_checks();
    case (ea)
      1:  chk("A.lit_cke",  ea, 32'(cke_a), 32'd1);
      10: begin chk("A.lit_pre", ea, 32'(cmd_a), 32'h2); chk("A.lit_pre_addr", ea, 32'(addr_a), 32'h400); end
      12: chk("A.lit_ref1", ea, 32'(cmd_a), 32'h1);
      19: chk("A.lit_ref2", ea, 32'(cmd_a), 32'h1);
      26: begin chk("A.lit_lmr", ea, 32'(cmd_a), 32'h0); chk("A.lit_lmr_addr", ea, 32'(addr_a), 32'h020); end
      27: chk("A.lit_done0", ea, 32'(done_a), 32'd0);
      28: chk("A.lit_done1", ea, 32'(done_a), 32'd1);
      default: ;
    endcase
    case (eb)
      10000: chk("B.lit_pre",   eb, 32'(cmd_b), 32'h2);
      10002: chk("B.lit_ref1",  eb, 32'(cmd_b), 32'h1);
      10030: chk("B.lit_ref8",  eb, 32'(cmd_b), 32'h1);
      10034: chk("B.lit_lmr",   eb, 32'(cmd_b), 32'h0);
      10035: chk("B.lit_done0", eb, 32'(done_b), 32'd0);
      10036: chk("B.lit_done1", eb, 32'(done_b), 32'd1);
      default: ;
    endcase
    case (ec)
      5:  chk("C.lit_pre",  ec, 32'(cmd_c), 32'h2);
      6, 7, 8: chk("C.lit_ref", ec, 32'(cmd_c), 32'h1);
      9:  begin chk("C.lit_lmr", ec, 32'(cmd_c), 32'h0); chk("C.lit_done0", ec, 32'(done_c), 32'd0); end
      10: chk("C.lit_done1", ec, 32'(done_c), 32'd1);
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check_inst("A", ea, 10, 2, 7, 2, 2, cke_a, cmd_a, addr_a, ba_a, done_a);
    check_inst("B", eb, 10000, 2, 4, 2, 8, cke_b, cmd_b, addr_b, ba_b, done_b);
    check_inst("C", ec, 5, 1, 1, 1, 3, cke_c, cmd_c, addr_c, ba_c, done_c);
    lit_checks();
  endtask

  initial begin
    int cyc;
    n_cmp = 0; n_bad = 0; pulsed = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    repeat (3) begin
      @(negedge clk);
      compare_all();
    end
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    cyc = 0;
    while (eb < 11040 && cyc < 12000) begin
      @(negedge clk);
      compare_all();
      cyc++;
      // Asynchronous mid-clock reset between A's two refreshes.
      if (!pulsed && ea == 16) begin
        pulsed = 1'b1;
        @(posedge clk);
        #3 rst_a = 1'b0;
        #1;
        chk("A.rst_cke",  ea, 32'(cke_a),  32'd0);
        chk("A.rst_cmd",  ea, 32'(cmd_a),  32'h7);
        chk("A.rst_addr", ea, 32'(addr_a), 32'h0);
        chk("A.rst_done", ea, 32'(done_a), 32'd0);
        @(negedge clk);
        compare_all();
        @(negedge clk);
        compare_all();
        rst_a = 1'b1;
      end
    end
    chk("B.budget", eb, 32'(eb >= 11040), 32'd1);
    chk("A.pulsed", ea, 32'(pulsed), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
